esm_dep_matrix_mt: RTL and testbench

//  Next-generation instruction dependency analyser for the ESM issue buffer. Tracks up to BS
//  in-flight instructions in a BS x BS dependency matrix and reports which slots are free of

---
 rtl/esm_dep_matrix_mt.sv | 145 ++++++++++++++
 tb/tb_esm_dep_matrix_mt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_dep_matrix_mt.sv
// Issue-buffer dependency matrix: per-slot RAW/WAW/WAR tracking with retirement
// and an ISSUE_W-lane lowest-index picker over hazard-free slots.
module esm_dep_matrix_mt #(
  parameter int unsigned IW       = 32,
  parameter int unsigned BS       = 16,
  parameter int unsigned REGNUM   = 32,
  parameter int unsigned HAZ_MODE = 0,
  parameter int unsigned X0_ZERO  = 1,
  parameter int unsigned ISSUE_W  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_valid,
  input  logic [$clog2(BS)-1:0]           alloc_idx,
  input  logic [IW-1:0]                   instr_in,
  input  logic                            reg_write,
  input  logic                            uses_rs2,
  input  logic [BS-1:0]                   retire_mask,
  output logic [BS-1:0]                   occupied,
  output logic [BS-1:0]                   independent,
  output logic [ISSUE_W-1:0]              issue_valid,
  output logic [ISSUE_W*$clog2(BS)-1:0]   issue_idx,
  output logic                            alloc_err
);

  localparam int unsigned AW = $clog2(BS);
  localparam int unsigned RA = $clog2(REGNUM);

  logic [BS-1:0]          r_occ;
  logic [BS-1:0][BS-1:0]  r_dep;
  logic [BS-1:0][RA-1:0]  r_rd;
  logic [BS-1:0][RA-1:0]  r_rs1;
  logic [BS-1:0][RA-1:0]  r_rs2;
  logic [BS-1:0]          r_rd_v;
  logic [BS-1:0]          r_rs2_v;
  logic                   r_alloc_err;

  logic [RA-1:0]          w_rd;
  logic [RA-1:0]          w_rs1;
  logic [RA-1:0]          w_rs2;
  logic                   w_accept;
  logic [BS-1:0]          w_new_dep;
  logic [BS-1:0]          w_col_clr;
  logic [BS-1:0]          w_occ_nxt;
  logic [BS-1:0][BS-1:0]  w_dep_nxt;
  logic [BS-1:0]          w_rem;
  logic                   w_hit;
  logic                   w_unused_instr;

  assign w_rd           = instr_in[7 +: RA];
  assign w_rs1          = instr_in[15 +: RA];
  assign w_rs2          = instr_in[20 +: RA];
  assign w_unused_instr = ^instr_in;

  // Register-equality test; register 0 optionally never matches.
  function automatic logic f_same(input logic [RA-1:0] x, input logic [RA-1:0] y);
    return (x == y) && !((X0_ZERO != 0) && (x == '0));
  endfunction

  // An allocation is accepted into a free slot or one retiring this same cycle.
  assign w_accept = alloc_valid & (~r_occ[alloc_idx] | retire_mask[alloc_idx]);

  // Hazards of the incoming instruction against every slot that stays live.
  always_comb begin
    w_new_dep = '0;
    for (int unsigned j = 0; j < BS; j++) begin
      w_new_dep[j] = r_occ[j] & ~retire_mask[j] & (AW'(j) != alloc_idx) & (
          (r_rd_v[j] & (f_same(w_rs1, r_rd[j]) | (uses_rs2 & f_same(w_rs2, r_rd[j]))))
        | ((HAZ_MODE >= 1) & reg_write & r_rd_v[j] & f_same(w_rd, r_rd[j]))
        | ((HAZ_MODE == 2) & reg_write &
           (f_same(w_rd, r_rs1[j]) | (r_rs2_v[j] & f_same(w_rd, r_rs2[j])))));
    end
  end

  // Retire clears columns; a new occupant also clears its own column and replaces its row.
  always_comb begin
    w_col_clr = retire_mask;
    w_occ_nxt = r_occ & ~retire_mask;
    if (w_accept) begin
      w_col_clr[alloc_idx] = 1'b1;
      w_occ_nxt[alloc_idx] = 1'b1;
    end
    w_dep_nxt = r_dep;
    for (int unsigned i = 0; i < BS; i++) begin
      w_dep_nxt[i] = r_dep[i] & ~w_col_clr;
    end
    if (w_accept) begin
      w_dep_nxt[alloc_idx] = w_new_dep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ       <= '0;
      r_dep       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd_v      <= '0;
      r_rs2_v     <= '0;
      r_alloc_err <= 1'b0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_dep       <= w_dep_nxt;
      r_alloc_err <= alloc_valid & ~w_accept;
      if (w_accept) begin
        r_rd[alloc_idx]    <= w_rd;
        r_rs1[alloc_idx]   <= w_rs1;
        r_rs2[alloc_idx]   <= w_rs2;
        r_rd_v[alloc_idx]  <= reg_write;
        r_rs2_v[alloc_idx] <= uses_rs2;
      end
    end
  end

  assign occupied  = r_occ;
  assign alloc_err = r_alloc_err;

  always_comb begin
    independent = '0;
    for (int unsigned i = 0; i < BS; i++) begin
      independent[i] = r_occ[i] & ~|r_dep[i];
    end
  end

  // Each lane takes the lowest remaining independent slot.
  always_comb begin
    w_rem       = independent;
    w_hit       = 1'b0;
    issue_valid = '0;
    issue_idx   = '0;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      w_hit = 1'b0;
      for (int unsigned i = 0; i < BS; i++) begin
        if (!w_hit && w_rem[i]) begin
          w_hit                 = 1'b1;
          w_rem[i]              = 1'b0;
          issue_valid[k]        = 1'b1;
          issue_idx[k*AW +: AW] = AW'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_esm_dep_matrix_mt.sv
// Bench for esm_dep_matrix_mt: four configurations (hazard modes, x0 handling) share one
// stimulus stream; directed table rows first, then random traffic against a slot-level model.
module tb_esm_dep_matrix_mt;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_idx;
  logic [31:0] instr_in;
  logic        reg_write;
  logic        uses_rs2;
  logic [15:0] retire_mask;

  logic [15:0] occ_o  [NC];
  logic [15:0] ind_o  [NC];
  logic [1:0]  iv_o   [NC];
  logic [7:0]  ix_o   [NC];
  logic        err_o  [NC];

  int cfg_mode [NC] = '{0, 1, 2, 2};
  bit cfg_x0   [NC] = '{1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  for (genvar c = 0; c < NC; c++) begin : g_dut
    esm_dep_matrix_mt #(
      .IW(32), .BS(16), .REGNUM(32),
      .HAZ_MODE((c == 0) ? 0 : ((c == 1) ? 1 : 2)),
      .X0_ZERO((c == 3) ? 0 : 1),
      .ISSUE_W(2)
    ) u_dut (
      .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
      .instr_in(instr_in), .reg_write(reg_write), .uses_rs2(uses_rs2),
      .retire_mask(retire_mask), .occupied(occ_o[c]), .independent(ind_o[c]),
      .issue_valid(iv_o[c]), .issue_idx(ix_o[c]), .alloc_err(err_o[c])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cfg%0d: got %0h want %0h", name, c, act, exp);
  endtask

  // Expected picker lanes: scan the independent set from slot 0 upward.
  task automatic check_cfg(input string tag, input int c, input bit [15:0] eocc,
                           input bit [15:0] eind, input bit eerr);
    int        picks[$];
    bit [1:0]  ev;
    bit [7:0]  ex;
    for (int i = 0; i < 16; i++) if (eind[i]) picks.push_back(i);
    ev = '0;
    ex = '0;
    if (picks.size() > 0) begin ev[0] = 1'b1; ex[3:0] = 4'(picks[0]); end
    if (picks.size() > 1) begin ev[1] = 1'b1; ex[7:4] = 4'(picks[1]); end
    chk({tag, ".occupied"},    c, 32'(occ_o[c]), 32'(eocc));
    chk({tag, ".independent"}, c, 32'(ind_o[c]), 32'(eind));
    chk({tag, ".issue_valid"}, c, 32'(iv_o[c]),  32'(ev));
    chk({tag, ".issue_idx"},   c, 32'(ix_o[c]),  32'(ex));
    chk({tag, ".alloc_err"},   c, 32'(err_o[c]), 32'(eerr));
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input logic [31:0] base);
    logic [31:0] w;
    w = base;
    w[11:7]  = 5'(rd);
    w[19:15] = 5'(rs1);
    w[24:20] = 5'(rs2);
    return w;
  endfunction

  typedef struct {
    bit        rst;
    bit        av;
    int        idx;
    int        rd, rs1, rs2;
    bit        regw, urs2;
    bit [15:0] ret;
    bit [15:0] occ;
    bit        err;
    bit [3:0][15:0] ind;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit av, input int idx, input int rd, input int rs1,
                              input int rs2, input bit regw, input bit urs2, input bit [15:0] ret,
                              input bit [15:0] occ, input bit err, input bit [15:0] i0,
                              input bit [15:0] i1, input bit [15:0] i2, input bit [15:0] i3);
    vec_t v;
    v.rst = r; v.av = av; v.idx = idx; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.regw = regw; v.urs2 = urs2; v.ret = ret; v.occ = occ; v.err = err;
    v.ind[0] = i0; v.ind[1] = i1; v.ind[2] = i2; v.ind[3] = i3;
    vecs.push_back(v);
  endfunction

  // Reference model: per-slot records plus, for each slot, the set of slots it waits on.
  bit [15:0] m_occ  [NC];
  bit [15:0] m_dep  [NC][16];
  int        m_rd   [NC][16];
  int        m_s1   [NC][16];
  int        m_s2   [NC][16];
  bit        m_rdv  [NC][16];
  bit        m_s2v  [NC][16];
  bit        m_err  [NC];

  function automatic bit same(input int x, input int y, input bit x0);
    return (x == y) && !(x0 && x == 0);
  endfunction

  task automatic model_step(input int c);
    int        a, rd, s1, s2;
    bit        acc;
    bit [15:0] nd;
    bit        raw, waw, war;
    if (!rst) begin
      m_occ[c] = '0;
      m_err[c] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_dep[c][i] = '0; m_rd[c][i] = 0; m_s1[c][i] = 0; m_s2[c][i] = 0;
        m_rdv[c][i] = 0; m_s2v[c][i] = 0;
      end
      return;
    end
    a  = int'(alloc_idx);
    rd = int'(instr_in[11:7]);
    s1 = int'(instr_in[19:15]);
    s2 = int'(instr_in[24:20]);
    acc = alloc_valid && (!m_occ[c][a] || retire_mask[a]);
    nd = '0;
    for (int j = 0; j < 16; j++) begin
      if (j != a && m_occ[c][j] && !retire_mask[j]) begin
        raw = m_rdv[c][j] && (same(s1, m_rd[c][j], cfg_x0[c]) ||
                              (uses_rs2 && same(s2, m_rd[c][j], cfg_x0[c])));
        waw = cfg_mode[c] >= 1 && reg_write && m_rdv[c][j] && same(rd, m_rd[c][j], cfg_x0[c]);
        war = cfg_mode[c] == 2 && reg_write && (same(rd, m_s1[c][j], cfg_x0[c]) ||
                                                (m_s2v[c][j] && same(rd, m_s2[c][j], cfg_x0[c])));
        nd[j] = raw || waw || war;
      end
    end
    for (int j = 0; j < 16; j++) begin
      if (retire_mask[j]) begin
        m_occ[c][j] = 1'b0;
        for (int i = 0; i < 16; i++) m_dep[c][i][j] = 1'b0;
      end
    end
    m_err[c] = alloc_valid && !acc;
    if (acc) begin
      for (int i = 0; i < 16; i++) m_dep[c][i][a] = 1'b0;
      m_dep[c][a] = nd;
      m_occ[c][a] = 1'b1;
      m_rd[c][a] = rd; m_s1[c][a] = s1; m_s2[c][a] = s2;
      m_rdv[c][a] = reg_write; m_s2v[c][a] = uses_rs2;
    end
  endtask

  function automatic bit [15:0] model_ind(input int c);
    bit [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = m_occ[c][i] && (m_dep[c][i] == '0);
    return r;
  endfunction

  initial begin
    rst = 1'b0; alloc_valid = 1'b0; alloc_idx = '0; instr_in = '0;
    reg_write = 1'b0; uses_rs2 = 1'b0; retire_mask = '0;

    // rst, av, idx, rd, rs1, rs2, regw, urs2, retire, occ, err, ind cfg0..cfg3
    add(0, 1, 0,  0,  0, 0, 1, 1, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  3,  0, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 1,  0,  3, 0, 0, 0, 16'h0000, 16'h0003, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0001, 16'h0002, 0, 16'h0002, 16'h0002, 16'h0002, 16'h0002);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  5,  7, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 1,  5,  6, 0, 1, 0, 16'h0000, 16'h0003, 0, 16'h0003, 16'h0001, 16'h0001, 16'h0001);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  5,  7, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 1,  7,  6, 0, 1, 0, 16'h0000, 16'h0003, 0, 16'h0003, 16'h0003, 16'h0001, 16'h0001);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  0,  1, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 1,  2,  0, 0, 1, 0, 16'h0000, 16'h0003, 0, 16'h0003, 16'h0003, 16'h0003, 16'h0001);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  4,  1, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 2,  0,  4, 0, 0, 0, 16'h0000, 16'h0005, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 0,  9,  9, 0, 1, 0, 16'h0000, 16'h0005, 1, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0000, 16'h0005, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 0,  9,  9, 0, 1, 0, 16'h0001, 16'h0005, 0, 16'h0005, 16'h0005, 16'h0005, 16'h0005);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 3,  10, 11, 0, 1, 0, 16'h0000, 16'h0008, 0, 16'h0008, 16'h0008, 16'h0008, 16'h0008);
    add(1, 1, 9,  12, 13, 0, 1, 0, 16'h0000, 16'h0208, 0, 16'h0208, 16'h0208, 16'h0208, 16'h0208);
    add(1, 1, 12, 14, 15, 0, 1, 0, 16'h0000, 16'h1208, 0, 16'h1208, 16'h1208, 16'h1208, 16'h1208);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(1, 1, 0,  6,  1, 0, 1, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 1,  0,  2, 6, 0, 1, 16'h0000, 16'h0003, 0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    add(1, 1, 2,  0,  2, 6, 0, 0, 16'h0000, 16'h0007, 0, 16'h0005, 16'h0005, 16'h0005, 16'h0005);
    add(1, 0, 0,  0,  0, 0, 0, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    @(negedge clk);
    foreach (vecs[n]) begin
      rst         = vecs[n].rst;
      alloc_valid = vecs[n].av;
      alloc_idx   = 4'(vecs[n].idx);
      instr_in    = mk(vecs[n].rd, vecs[n].rs1, vecs[n].rs2, 32'h0000_0033);
      reg_write   = vecs[n].regw;
      uses_rs2    = vecs[n].urs2;
      retire_mask = vecs[n].ret;
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
        check_cfg($sformatf("vec%0d", n), c, vecs[n].occ, vecs[n].ind[c], vecs[n].err);
    end

    // Random traffic; small register range so hazards and x0 matches are frequent.
    rst = 1'b0;
    for (int c = 0; c < NC; c++) model_step(c);
    @(posedge clk);
    #1;
    for (int t = 0; t < 600; t++) begin
      rst         = ($urandom_range(0, 59) != 0);
      alloc_valid = ($urandom_range(0, 9) < 7);
      alloc_idx   = 4'($urandom_range(0, 15));
      instr_in    = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      reg_write   = 1'($urandom_range(0, 1));
      uses_rs2    = 1'($urandom_range(0, 1));
      retire_mask = '0;
      for (int j = 0; j < 16; j++) retire_mask[j] = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NC; c++) model_step(c);
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++)
        check_cfg($sformatf("rnd%0d", t), c, m_occ[c], model_ind(c), m_err[c]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
